fetch_queue: RTL and testbench

Front-end sequencer and instruction buffer on the consumer side of the `fetch` byte-memory port. It drives `fetch_pc` and captures the two little-endian instruction words that `fetch` returns one cycle later. Each word is buffered with its PC in a circular queue and presented to decode as up to two in-order instructions per cycle. It handles back-pressure, branch redirects and end-of-program.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue_ring.sv | 66 ++++++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end: queue entry layout
// and the deq_take clamp used by the ring.
package fetch_pkg;

    localparam int INST_W      = 32;
    localparam int PC_W        = 8;
    localparam int FETCH_BYTES = 8;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fq_entry_t;

    // Decode can never consume more than the two presented slots.
    function automatic logic [1:0] clamp_take(input logic [1:0] take);
        return (take == 2'd3) ? 2'd2 : take;
    endfunction

endpackage

// File: rtl/fetch_queue_ring.sv
// Circular instruction buffer: two write ports filled as a pair at the tail,
// two combinational read ports at the head, dequeue clamped to occupancy.
module fetch_queue_ring
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fq_entry_t     i_wdata0,
    input  fq_entry_t     i_wdata1,
    input  logic [1:0]    i_take,
    output logic [CW-1:0] o_count,
    output fq_entry_t     o_rdata0,
    output fq_entry_t     o_rdata1
);

    fq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [1:0]    w_take;
    logic [1:0]    w_n;
    logic [PW-1:0] w_head1;
    logic [PW-1:0] w_tail1;

    assign w_take  = clamp_take(i_take);
    assign w_n     = (r_count < CW'(w_take)) ? r_count[1:0] : w_take;
    assign w_head1 = r_head + PW'(1);
    assign w_tail1 = r_tail + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= r_tail + PW'(2);
            end
            r_head  <= r_head + PW'(w_n);
            r_count <= r_count + (i_push ? CW'(2) : CW'(0)) - CW'(w_n);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_tail]  <= i_wdata0;
            r_mem[w_tail1] <= i_wdata1;
        end
    end

    assign o_count  = r_count;
    assign o_rdata0 = r_mem[r_head];
    assign o_rdata1 = r_mem[w_head1];

endmodule

// File: rtl/fetch_queue.sv
// Fetch sequencer: issues 8-byte requests, captures the returned pair one
// edge later into the ring, and handles redirects and end-of-program.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int MEM_BYTES = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   fetch_pc,
    input  logic [INST_W-1:0] fetch_inst1,
    input  logic [INST_W-1:0] fetch_inst2,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid0,
    output logic              out_valid1,
    output logic [INST_W-1:0] out_inst0,
    output logic [INST_W-1:0] out_inst1,
    output logic [PC_W-1:0]   out_pc0,
    output logic [PC_W-1:0]   out_pc1,
    input  logic [1:0]        deq_take,
    output logic              done
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W:0]   r_pc;
    logic            r_inflV;
    logic [PC_W-1:0] r_inflPc;
    logic [CW-1:0]   w_count;
    fq_entry_t       w_rd0;
    fq_entry_t       w_rd1;
    fq_entry_t       w_wr0;
    fq_entry_t       w_wr1;
    logic            w_pcRoom;
    logic            w_qRoom;
    logic            w_issue;
    logic            w_push;

    // Queue room counts the in-flight pair so a capture can never overflow.
    assign w_pcRoom = (int'(r_pc) + FETCH_BYTES) <= MEM_BYTES;
    assign w_qRoom  = (int'(w_count) + (r_inflV ? 4 : 2)) <= DEPTH;
    assign w_issue  = !redirect_valid && w_pcRoom && w_qRoom;
    assign w_push   = r_inflV && !redirect_valid;

    assign w_wr0 = '{inst: fetch_inst1, pc: r_inflPc};
    assign w_wr1 = '{inst: fetch_inst2, pc: r_inflPc + PC_W'(4)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= '0;
            r_inflV  <= 1'b0;
            r_inflPc <= '0;
        end else if (redirect_valid) begin
            r_pc    <= {1'b0, redirect_pc & 8'hFC};
            r_inflV <= 1'b0;
        end else if (w_issue) begin
            r_inflV  <= 1'b1;
            r_inflPc <= r_pc[PC_W-1:0];
            r_pc     <= r_pc + (PC_W+1)'(FETCH_BYTES);
        end else begin
            r_inflV <= 1'b0;
        end
    end

    fetch_queue_ring #(.DEPTH(DEPTH)) u_ring (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (redirect_valid),
        .i_push   (w_push),
        .i_wdata0 (w_wr0),
        .i_wdata1 (w_wr1),
        .i_take   (deq_take),
        .o_count  (w_count),
        .o_rdata0 (w_rd0),
        .o_rdata1 (w_rd1)
    );

    assign fetch_pc   = r_pc[PC_W-1:0];
    assign out_valid0 = (w_count != '0);
    assign out_valid1 = (w_count >= CW'(2));
    assign out_inst0  = out_valid0 ? w_rd0.inst : '0;
    assign out_pc0    = out_valid0 ? w_rd0.pc   : '0;
    assign out_inst1  = out_valid1 ? w_rd1.inst : '0;
    assign out_pc1    = out_valid1 ? w_rd1.pc   : '0;
    assign done       = !w_pcRoom && (w_count == '0) && !r_inflV;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a one-edge-latency byte memory model
// whose word at address A is {24'hC0DE5A, A}.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  fetch_pc;
    logic [31:0] fetch_inst1 = '0;
    logic [31:0] fetch_inst2 = '0;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid0, out_valid1;
    logic [31:0] out_inst0, out_inst1;
    logic [7:0]  out_pc0, out_pc1;
    logic [1:0]  deq_take;
    logic        done;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.DEPTH(8), .MEM_BYTES(128)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .fetch_inst1    (fetch_inst1),
        .fetch_inst2    (fetch_inst2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid0     (out_valid0),
        .out_valid1     (out_valid1),
        .out_inst0      (out_inst0),
        .out_inst1      (out_inst1),
        .out_pc0        (out_pc0),
        .out_pc1        (out_pc1),
        .deq_take       (deq_take),
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [7:0] a);
        return {24'hC0DE5A, a};
    endfunction

    // Memory samples fetch_pc at the edge and returns the pair after it.
    always @(posedge clk) begin
        fetch_inst1 <= memWord(fetch_pc);
        fetch_inst2 <= memWord(fetch_pc + 8'd4);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        deq_take       = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid0: got %b expected 0", out_valid0); end
        checks++; if (fetch_pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_fetch_pc: got %h expected 00", fetch_pc); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (out_inst0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst0: got %h expected 0", out_inst0); end
    endtask

    task automatic test_stall();
        applyReset();
        tick();
        checks++; if (fetch_pc !== 8'h08) begin errors++; $display("[TB] FAIL stall_first_issue: got %h expected 08", fetch_pc); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL stall_early_valid: got %b expected 0", out_valid0); end
        repeat (7) tick();
        checks++; if (fetch_pc !== 8'h20) begin errors++; $display("[TB] FAIL stall_fetch_pc: got %h expected 20", fetch_pc); end
        checks++; if (out_valid1 !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid1: got %b expected 1", out_valid1); end
        checks++; if (out_pc0 !== 8'h00) begin errors++; $display("[TB] FAIL stall_pc0: got %h expected 00", out_pc0); end
        checks++; if (out_pc1 !== 8'h04) begin errors++; $display("[TB] FAIL stall_pc1: got %h expected 04", out_pc1); end
        checks++; if (out_inst1 !== memWord(8'h04)) begin errors++; $display("[TB] FAIL stall_inst1: got %h expected %h", out_inst1, memWord(8'h04)); end
    endtask

    task automatic test_stream();
        logic [7:0] expPc;
        applyReset();
        deq_take = 2'd2;
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL stream_latency: got %b expected 0", out_valid0); end
        for (int i = 0; i < 16; i++) begin
            tick();
            expPc = 8'(8 * i);
            checks++; if ({out_valid0, out_valid1} !== 2'b11) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 11", i, {out_valid0, out_valid1}); end
            checks++; if (out_pc0 !== expPc) begin errors++; $display("[TB] FAIL stream_pc0[%0d]: got %h expected %h", i, out_pc0, expPc); end
            checks++; if (out_pc1 !== expPc + 8'd4) begin errors++; $display("[TB] FAIL stream_pc1[%0d]: got %h expected %h", i, out_pc1, expPc + 8'd4); end
            checks++; if (out_inst0 !== memWord(expPc)) begin errors++; $display("[TB] FAIL stream_inst0[%0d]: got %h expected %h", i, out_inst0, memWord(expPc)); end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL stream_done_early[%0d]: got %b expected 0", i, done); end
        end
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained: got %b expected 0", out_valid0); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL stream_done: got %b expected 1", done); end
        deq_take = 2'd0;
    endtask

    task automatic test_redirect();
        applyReset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h41;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %b expected 0", out_valid0); end
        checks++; if (fetch_pc !== 8'h40) begin errors++; $display("[TB] FAIL redir_fetch_pc: got %h expected 40", fetch_pc); end
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL redir_stale: got %b expected 0", out_valid0); end
        checks++; if (fetch_pc !== 8'h48) begin errors++; $display("[TB] FAIL redir_issue: got %h expected 48", fetch_pc); end
        tick();
        checks++; if (out_valid0 !== 1'b1) begin errors++; $display("[TB] FAIL redir_valid0: got %b expected 1", out_valid0); end
        checks++; if (out_pc0 !== 8'h40) begin errors++; $display("[TB] FAIL redir_pc0: got %h expected 40", out_pc0); end
        checks++; if (out_pc1 !== 8'h44) begin errors++; $display("[TB] FAIL redir_pc1: got %h expected 44", out_pc1); end
        checks++; if (out_inst0 !== memWord(8'h40)) begin errors++; $display("[TB] FAIL redir_inst0: got %h expected %h", out_inst0, memWord(8'h40)); end
    endtask

    task automatic test_end_of_program();
        applyReset();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h78;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_pc !== 8'h78) begin errors++; $display("[TB] FAIL eop_redir_pc: got %h expected 78", fetch_pc); end
        tick();
        checks++; if (fetch_pc !== 8'h80) begin errors++; $display("[TB] FAIL eop_issue: got %h expected 80", fetch_pc); end
        tick();
        checks++; if (out_pc0 !== 8'h78) begin errors++; $display("[TB] FAIL eop_pc0: got %h expected 78", out_pc0); end
        checks++; if (out_pc1 !== 8'h7C) begin errors++; $display("[TB] FAIL eop_pc1: got %h expected 7c", out_pc1); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL eop_done_pending: got %b expected 0", done); end
        tick();
        checks++; if (fetch_pc !== 8'h80) begin errors++; $display("[TB] FAIL eop_no_issue: got %h expected 80", fetch_pc); end
        deq_take = 2'd1;
        tick();
        checks++; if (out_pc0 !== 8'h7C) begin errors++; $display("[TB] FAIL eop_one_left: got %h expected 7c", out_pc0); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("[TB] FAIL eop_valid1: got %b expected 0", out_valid1); end
        deq_take = 2'd3;
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL take3_empty: got %b expected 0", out_valid0); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL eop_done: got %b expected 1", done); end
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("[TB] FAIL take3_underflow: got %b expected 0", out_valid0); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL eop_done_hold: got %b expected 1", done); end
        deq_take = 2'd0;
    endtask

    task automatic test_async_reset();
        applyReset();
        repeat (4) tick();
        checks++; if (out_pc1 !== 8'h04) begin errors++; $display("[TB] FAIL areset_pre_pc1: got %h expected 04", out_pc1); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid0, out_valid1} !== 2'b00) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 00", {out_valid0, out_valid1}); end
        checks++; if (fetch_pc !== 8'h00) begin errors++; $display("[TB] FAIL areset_fetch_pc: got %h expected 00", fetch_pc); end
        checks++; if (out_inst0 !== 32'h0) begin errors++; $display("[TB] FAIL areset_inst0: got %h expected 0", out_inst0); end
        checks++; if (out_pc1 !== 8'h00) begin errors++; $display("[TB] FAIL areset_pc1: got %h expected 00", out_pc1); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (fetch_pc !== 8'h08) begin errors++; $display("[TB] FAIL areset_restart: got %h expected 08", fetch_pc); end
        tick();
        checks++; if (out_pc0 !== 8'h00) begin errors++; $display("[TB] FAIL areset_pc0: got %h expected 00", out_pc0); end
        checks++; if (out_inst0 !== memWord(8'h00)) begin errors++; $display("[TB] FAIL areset_inst0_after: got %h expected %h", out_inst0, memWord(8'h00)); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_stream();
        test_redirect();
        test_end_of_program();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
